// File: rtl/dmem_access_ctrl.sv
// MEM-stage data memory access controller: req/ack handshake, store lane steering,
// load extension, misalignment detection. Define DMEM_TIMEOUT_EN to enable the REQ abort timer.
module dmem_access_ctrl #(
    parameter int ADDR_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              MemEN_s4,
    input  logic              MemRead_s4,
    input  logic              MemWrite_s4,
    input  logic [2:0]        funct3_s4,
    input  logic [ADDR_W-1:0] addr_s4,
    input  logic [31:0]       wdata_s4,
    output logic [31:0]       rdata_s4,
    output logic              stall_mem,
    output logic              mem_err,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic [3:0]        mem_wstrb,
    input  logic              mem_ack,
    input  logic [31:0]       mem_rdata
);

    typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

    state_t      state, state_nxt;
    logic        acc, we_in, aligned, tmo_hit;
    logic [3:0]  strb_fmt;
    logic [31:0] wdata_fmt, load_ext;
    logic        we_q, err_q;
    logic [2:0]  funct3_q;
    logic [1:0]  lane_q;
    logic [7:0]  rbyte;
    logic [15:0] rhalf;

    assign acc   = MemEN_s4 & (MemRead_s4 | MemWrite_s4);
    assign we_in = MemWrite_s4 & ~MemRead_s4;

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        aligned   = 1'b1;
        strb_fmt  = 4'b1111;
        wdata_fmt = wdata_s4;
        case (funct3_s4[1:0])
            2'b00: begin
                strb_fmt  = 4'b0001 << addr_s4[1:0];
                wdata_fmt = {4{wdata_s4[7:0]}};
            end
            2'b01: begin
                aligned   = ~addr_s4[0];
                strb_fmt  = 4'b0011 << {addr_s4[1], 1'b0};
                wdata_fmt = {2{wdata_s4[15:0]}};
            end
            default: aligned = (addr_s4[1:0] == 2'b00);
        endcase
    end

    // Load extension works on the funct3/lane captured at request time.
    always_comb begin
        rbyte    = mem_rdata[{lane_q, 3'b000} +: 8];
        rhalf    = lane_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        load_ext = mem_rdata;
        case (funct3_q)
            3'b000:  load_ext = {{24{rbyte[7]}}, rbyte};
            3'b100:  load_ext = {24'h0, rbyte};
            3'b001:  load_ext = {{16{rhalf[15]}}, rhalf};
            3'b101:  load_ext = {16'h0, rhalf};
            default: load_ext = mem_rdata;
        endcase
    end

`ifdef DMEM_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    logic [CNT_W-1:0] tmo_cnt;

    // Hit on the TIMEOUT-th REQ cycle, i.e. when the counter would step to TIMEOUT.
    assign tmo_hit = (tmo_cnt == CNT_W'(TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (rst || state != REQ) tmo_cnt <= '0;
        else if (!mem_ack)       tmo_cnt <= tmo_cnt + 1'b1;
    end
`else
    logic unused_timeout;
    assign tmo_hit        = 1'b0;
    assign unused_timeout = (TIMEOUT != 0);
`endif

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (acc) state_nxt = aligned ? REQ : DONE;
            REQ:     if (mem_ack || tmo_hit) state_nxt = DONE;
            default: state_nxt = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            we_q      <= 1'b0;
            err_q     <= 1'b0;
            funct3_q  <= 3'b000;
            lane_q    <= 2'b00;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_wstrb <= '0;
            rdata_s4  <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    if (acc && aligned) begin
                        we_q      <= we_in;
                        err_q     <= 1'b0;
                        funct3_q  <= funct3_s4;
                        lane_q    <= addr_s4[1:0];
                        mem_addr  <= {addr_s4[ADDR_W-1:2], 2'b00};
                        mem_wdata <= we_in ? wdata_fmt : 32'h0;
                        mem_wstrb <= we_in ? strb_fmt  : 4'b0000;
                    end else if (acc) begin
                        err_q    <= 1'b1;
                        rdata_s4 <= '0;
                    end
                end
                REQ: begin
                    if (mem_ack) begin
                        rdata_s4 <= we_q ? 32'h0 : load_ext;
                    end else if (tmo_hit) begin
                        err_q    <= 1'b1;
                        rdata_s4 <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign mem_req   = (state == REQ);
    assign mem_we    = mem_req & we_q;
    assign mem_err   = (state == DONE) & err_q;
    assign stall_mem = ~rst & acc & (state != DONE);

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Directed bench for dmem_access_ctrl: handshake timing, lane steering, extension,
// misalignment, reset during REQ, and the optional timeout (when DMEM_TIMEOUT_EN is defined).
module tb_dmem_access_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        MemEN_s4, MemRead_s4, MemWrite_s4;
    logic [2:0]  funct3_s4;
    logic [31:0] addr_s4, wdata_s4;
    logic [31:0] rdata_s4;
    logic        stall_mem, mem_err, mem_req, mem_we;
    logic [31:0] mem_addr, mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    int total = 0;
    int bad   = 0;

    dmem_access_ctrl #(.ADDR_W(32), .TIMEOUT(4)) dut (
        .clk(clk), .rst(rst),
        .MemEN_s4(MemEN_s4), .MemRead_s4(MemRead_s4), .MemWrite_s4(MemWrite_s4),
        .funct3_s4(funct3_s4), .addr_s4(addr_s4), .wdata_s4(wdata_s4),
        .rdata_s4(rdata_s4), .stall_mem(stall_mem), .mem_err(mem_err),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Inputs change 1 ns after the rising edge; outputs are sampled 1 ns later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic start(input logic rd, input logic wr, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] wd);
        MemEN_s4 = 1'b1; MemRead_s4 = rd; MemWrite_s4 = wr;
        funct3_s4 = f3; addr_s4 = a; wdata_s4 = wd;
        settle();
        check("c0_stall", {31'h0, stall_mem}, 32'h1);
        check("c0_req",   {31'h0, mem_req},   32'h0);
    endtask

    // Walk REQ cycles 1..n with ack at cycle n, then step into DONE.
    task automatic ack_at(input int n, input logic [31:0] rd, input logic exp_we,
                          input logic [3:0] exp_strb, input logic [31:0] exp_wdata,
                          input logic [31:0] exp_addr);
        for (int i = 1; i <= n; i++) begin
            tick();
            if (i == n) begin
                mem_ack = 1'b1; mem_rdata = rd;
            end
            settle();
            check("req_high",  {31'h0, mem_req},   32'h1);
            check("req_stall", {31'h0, stall_mem}, 32'h1);
            check("req_we",    {31'h0, mem_we},    {31'h0, exp_we});
            check("req_strb",  {28'h0, mem_wstrb}, {28'h0, exp_strb});
            check("req_addr",  mem_addr,           exp_addr);
            if (exp_we) check("req_wdata", mem_wdata, exp_wdata);
        end
        tick();
        mem_ack = 1'b0; mem_rdata = 32'hA5A5_5A5A;
        settle();
        check("done_stall", {31'h0, stall_mem}, 32'h0);
        check("done_req",   {31'h0, mem_req},   32'h0);
    endtask

    // Pipeline advances out of DONE: next cycle is IDLE with no access presented.
    task automatic retire();
        tick();
        MemEN_s4 = 1'b0; MemRead_s4 = 1'b0; MemWrite_s4 = 1'b0;
        settle();
        check("idle_req",   {31'h0, mem_req},   32'h0);
        check("idle_stall", {31'h0, stall_mem}, 32'h0);
        check("idle_err",   {31'h0, mem_err},   32'h0);
    endtask

    initial begin
        rst = 1'b1; mem_ack = 1'b0; mem_rdata = 32'h0;
        MemEN_s4 = 1'b1; MemRead_s4 = 1'b1; MemWrite_s4 = 1'b0;
        funct3_s4 = 3'b010; addr_s4 = 32'h0; wdata_s4 = 32'h0;
        settle();
        check("rst_stall_forced", {31'h0, stall_mem}, 32'h0);
        tick();
        check("rst_req",   {31'h0, mem_req},   32'h0);
        check("rst_we",    {31'h0, mem_we},    32'h0);
        check("rst_err",   {31'h0, mem_err},   32'h0);
        check("rst_addr",  mem_addr,           32'h0);
        check("rst_wdata", mem_wdata,          32'h0);
        check("rst_wstrb", {28'h0, mem_wstrb}, 32'h0);
        check("rst_rdata", rdata_s4,           32'h0);
        MemEN_s4 = 1'b0;
        tick();
        rst = 1'b0;
        settle();
        check("post_rst_stall", {31'h0, stall_mem}, 32'h0);

        // LW 0x100, ack at cycle 3
        start(1'b1, 1'b0, 3'b010, 32'h0000_0100, 32'h0);
        ack_at(3, 32'hDEAD_BEEF, 1'b0, 4'b0000, 32'h0, 32'h0000_0100);
        check("lw_rdata", rdata_s4, 32'hDEAD_BEEF);
        check("lw_err",   {31'h0, mem_err}, 32'h0);
        retire();

        // LB / LBU 0x103 — back-to-back with the retire cycle
        start(1'b1, 1'b0, 3'b000, 32'h0000_0103, 32'h0);
        ack_at(1, 32'h8011_2233, 1'b0, 4'b0000, 32'h0, 32'h0000_0100);
        check("lb_rdata", rdata_s4, 32'hFFFF_FF80);
        retire();
        start(1'b1, 1'b0, 3'b100, 32'h0000_0103, 32'h0);
        ack_at(2, 32'h8011_2233, 1'b0, 4'b0000, 32'h0, 32'h0000_0100);
        check("lbu_rdata", rdata_s4, 32'h0000_0080);
        retire();

        // LH upper half (sign), LHU lower half
        start(1'b1, 1'b0, 3'b001, 32'h0000_0102, 32'h0);
        ack_at(1, 32'h8011_2233, 1'b0, 4'b0000, 32'h0, 32'h0000_0100);
        check("lh_rdata", rdata_s4, 32'hFFFF_8011);
        retire();
        start(1'b1, 1'b0, 3'b101, 32'h0000_0100, 32'h0);
        ack_at(1, 32'h8011_A233, 1'b0, 4'b0000, 32'h0, 32'h0000_0100);
        check("lhu_rdata", rdata_s4, 32'h0000_A233);
        retire();

        // Misaligned LW 0x101 right after a load left rdata nonzero
        start(1'b1, 1'b0, 3'b010, 32'h0000_0101, 32'h0);
        tick();
        settle();
        check("mis_lw_req",   {31'h0, mem_req},   32'h0);
        check("mis_lw_stall", {31'h0, stall_mem}, 32'h0);
        check("mis_lw_err",   {31'h0, mem_err},   32'h1);
        check("mis_lw_rdata", rdata_s4,           32'h0);
        retire();

        // SH 0x102
        start(1'b0, 1'b1, 3'b001, 32'h0000_0102, 32'h0000_ABCD);
        ack_at(2, 32'h1111_1111, 1'b1, 4'b1100, 32'hABCD_ABCD, 32'h0000_0100);
        check("sh_rdata", rdata_s4, 32'h0);
        check("sh_err",   {31'h0, mem_err}, 32'h0);
        retire();

        // SB 0x101, SW 0x104
        start(1'b0, 1'b1, 3'b000, 32'h0000_0101, 32'h1234_56A5);
        ack_at(1, 32'h0, 1'b1, 4'b0010, 32'hA5A5_A5A5, 32'h0000_0100);
        retire();
        start(1'b0, 1'b1, 3'b010, 32'h0000_0104, 32'hCAFE_F00D);
        ack_at(1, 32'h0, 1'b1, 4'b1111, 32'hCAFE_F00D, 32'h0000_0104);
        retire();

        // Misaligned SH 0x101: no request, no write, error pulse
        start(1'b0, 1'b1, 3'b001, 32'h0000_0101, 32'h0000_FFFF);
        tick();
        settle();
        check("mis_sh_req", {31'h0, mem_req}, 32'h0);
        check("mis_sh_we",  {31'h0, mem_we},  32'h0);
        check("mis_sh_err", {31'h0, mem_err}, 32'h1);
        retire();

        // Read wins over write; unknown funct3 behaves as LW
        start(1'b1, 1'b1, 3'b011, 32'h0000_0108, 32'hFFFF_FFFF);
        ack_at(1, 32'h1234_5678, 1'b0, 4'b0000, 32'h0, 32'h0000_0108);
        check("rw_f3x_rdata", rdata_s4, 32'h1234_5678);
        retire();

        // Ack while IDLE is ignored
        mem_ack = 1'b1; mem_rdata = 32'h7777_7777;
        tick();
        mem_ack = 1'b0;
        settle();
        check("idle_ack_req",   {31'h0, mem_req}, 32'h0);
        check("idle_ack_err",   {31'h0, mem_err}, 32'h0);
        check("idle_ack_rdata", rdata_s4,         32'h1234_5678);

        // Reset during REQ, late ack the following cycle
        start(1'b1, 1'b0, 3'b010, 32'h0000_010C, 32'h0);
        tick();
        settle();
        check("rreq_req", {31'h0, mem_req}, 32'h1);
        rst = 1'b1;
        settle();
        check("rreq_stall_forced", {31'h0, stall_mem}, 32'h0);
        tick();
        rst = 1'b0; MemEN_s4 = 1'b0; mem_ack = 1'b1; mem_rdata = 32'h9999_9999;
        settle();
        check("rreq_req_low", {31'h0, mem_req},   32'h0);
        check("rreq_stall",   {31'h0, stall_mem}, 32'h0);
        tick();
        mem_ack = 1'b0;
        settle();
        check("rreq_no_done_err", {31'h0, mem_err}, 32'h0);
        check("rreq_no_capture",  rdata_s4,         32'h0);
        check("rreq_idle_req",    {31'h0, mem_req}, 32'h0);

`ifdef DMEM_TIMEOUT_EN
        // TIMEOUT=4 with no ack: 4 REQ cycles, then DONE with error
        start(1'b1, 1'b0, 3'b010, 32'h0000_0200, 32'h0);
        for (int i = 1; i <= 4; i++) begin
            tick();
            settle();
            check("tmo_req_high", {31'h0, mem_req}, 32'h1);
        end
        tick();
        settle();
        check("tmo_req_low", {31'h0, mem_req},   32'h0);
        check("tmo_err",     {31'h0, mem_err},   32'h1);
        check("tmo_stall",   {31'h0, stall_mem}, 32'h0);
        check("tmo_rdata",   rdata_s4,           32'h0);
        retire();
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
